// File: rtl/bsram_arb_pkg.sv
// Shared types and constants for the BSRAM port arbiter.
// Fixed Gowin BSRAM pin widths, FSM state type, response tag and read-latency helper.
package bsram_arb_pkg;

  localparam int BSRAM_AD_W = 14;
  localparam int BSRAM_D_W  = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic rd;
    logic id;
  } rsp_tag_t;

  function automatic int rd_latency(input logic read_mode);
    return read_mode ? 2 : 1;
  endfunction

endpackage

// File: rtl/bsram_rr_grant.sv
// Two-way round-robin grant: combinational one-hot grant from the valid inputs
// and a priority bit that moves only when a transfer is accepted.
module bsram_rr_grant (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // prio = 0 favours requester 0, prio = 1 favours requester 1
  logic prio;

  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~prio);
    grant[1] = valid[1] & (~valid[0] |  prio);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/bsram_port_arbiter.sv
// Shares one Gowin BSRAM port between two valid/ready requesters: zero-fills the RAM
// after reset, then issues one access per cycle round-robin and routes read data back.
//
// state | meaning
// INIT  | zero-fill every address (or skip straight through when INIT_CLEAR=0)
// RUN   | round-robin arbitration of requester accesses
module bsram_port_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int   ADDR_WIDTH = 11,
  parameter int   DATA_WIDTH = 8,
  parameter logic READ_MODE  = 1'b0,
  parameter int   INIT_CLEAR = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_we,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    init_done,
  output logic                    ram_ce,
  output logic                    ram_oce,
  output logic                    ram_wre,
  output logic                    ram_reset,
  output logic [BSRAM_AD_W-1:0]   ram_ad,
  output logic [BSRAM_D_W-1:0]    ram_di,
  input  logic [BSRAM_D_W-1:0]    ram_do
);

  localparam int LAT   = rd_latency(READ_MODE);
  localparam int AD_SH = BSRAM_AD_W - ADDR_WIDTH;

  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [1:0]            grant;
  logic [1:0]            ready;
  logic                  acc;
  logic                  sel_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  rsp_tag_t              iss_tag;
  rsp_tag_t              tag_q [LAT];

  bsram_rr_grant u_grant (
    .clk    (CLK),
    .reset  (RESET),
    .valid  ({req1_valid, req0_valid}),
    .accept (acc),
    .grant  (grant)
  );

  // ready is withheld during reset so nothing is "accepted" into a cleared pipeline
  assign ready      = grant & {2{(state == RUN) & ~RESET}};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign acc        = |ready;

  assign sel_id    = ready[1];
  assign sel_we    = sel_id ? req1_we    : req0_we;
  assign sel_addr  = sel_id ? req1_addr  : req0_addr;
  assign sel_wdata = sel_id ? req1_wdata : req0_wdata;

  assign ram_reset = RESET;
  assign ram_oce   = 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      ram_ce    <= 1'b0;
      ram_wre   <= 1'b0;
      ram_ad    <= '0;
      ram_di    <= '0;
      iss_tag   <= '0;
    end else begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      iss_tag <= '0;
      unique case (state)
        INIT: begin
          if (INIT_CLEAR != 0) begin
            ram_ce  <= 1'b1;
            ram_wre <= 1'b1;
            ram_ad  <= BSRAM_AD_W'(clr_cnt) << AD_SH;
            ram_di  <= '0;
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            if (&clr_cnt) begin
              state     <= RUN;
              init_done <= 1'b1;
            end
          end else begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (acc) begin
            ram_ce  <= 1'b1;
            ram_wre <= sel_we;
            ram_ad  <= BSRAM_AD_W'(sel_addr) << AD_SH;
            ram_di  <= BSRAM_D_W'(sel_wdata);
            iss_tag <= '{rd: ~sel_we, id: sel_id};
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // tag follows the access through the RAM's sampling edge plus its output latency
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= iss_tag;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp0_valid = tag_q[LAT-1].rd & ~tag_q[LAT-1].id;
  assign rsp1_valid = tag_q[LAT-1].rd &  tag_q[LAT-1].id;
  assign rsp0_rdata = ram_do[DATA_WIDTH-1:0];
  assign rsp1_rdata = ram_do[DATA_WIDTH-1:0];

  if (DATA_WIDTH < BSRAM_D_W) begin : g_do_hi
    logic unused_do_hi;
    assign unused_do_hi = ^ram_do[BSRAM_D_W-1:DATA_WIDTH];
  end

endmodule
